// File: rtl/prime_sweep_ctrl.sv
// Sweep sequencer for a shared prime-test core: walks [lo, hi], issues one candidate
// at a time, streams primes over valid/ready and flags a hung core via timeout.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | present cand to the core (skipped for cand < 2)
// WAIT   | core busy, timeout counter running
// EMIT   | prime on p_data, waiting for p_ready
// FINISH | one-cycle done pulse
module prime_sweep_ctrl #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic         chk_start,
    output logic [W-1:0] chk_n,
    input  logic         chk_done,
    input  logic         chk_is_prime,
    output logic         p_valid,
    output logic [W-1:0] p_data,
    input  logic         p_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] prime_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_FINISH
    } state_t;

    // Down-counter loaded at issue; the WAIT cycle that sees 1 is the last one allowed.
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);
    localparam logic [W-1:0] CNT_MAX = '1;

    state_t         state_q, state_d;
    logic [W-1:0]   cand_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   cnt_q;
    logic [15:0]    tmr_q;
    logic           err_q;

    logic           cand_lt2;
    logic           capture;
    logic           advance;
    logic           issue;
    logic           tmo;
    logic           accept;

    assign cand_lt2 = (cand_q < W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        issue   = 1'b0;
        tmo     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = (lo > hi) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cand_lt2) begin
                    advance = 1'b1;
                end else begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chk_done) begin
                    if (chk_is_prime) begin
                        state_d = S_EMIT;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tmr_q <= 16'd1) begin
                    tmo     = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_EMIT: begin
                if (p_ready) begin
                    accept  = 1'b1;
                    advance = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stopping on equality keeps cand from wrapping when hi is all-ones.
        if (advance) begin
            state_d = (cand_q == hi_q) ? S_FINISH : S_ISSUE;
        end

        if (abort) begin
            state_d = S_IDLE;
            capture = 1'b0;
            advance = 1'b0;
            issue   = 1'b0;
            tmo     = 1'b0;
            accept  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= '0;
            hi_q   <= '0;
            cnt_q  <= '0;
            tmr_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (capture) begin
                cand_q <= lo;
                hi_q   <= hi;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end
            if (advance && (cand_q != hi_q)) begin
                cand_q <= cand_q + W'(1);
            end
            if (issue) begin
                tmr_q <= TMR_LOAD;
            end else if ((state_q == S_WAIT) && (tmr_q != 16'd0)) begin
                tmr_q <= tmr_q - 16'd1;
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
            if (accept && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + W'(1);
            end
        end
    end

    assign chk_start   = (state_q == S_ISSUE) && !cand_lt2;
    assign chk_n       = cand_q;
    assign p_valid     = (state_q == S_EMIT);
    assign p_data      = cand_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign err         = err_q;
    assign prime_count = cnt_q;

endmodule
